// File: rtl/countdown_timer_60_pkg.sv
// -----------------------------------------------------------------------------
// countdown_timer_60_pkg
// Shared definitions for the 0..59 second countdown timer:
//   - state_t     : controller states (IDLE, RUN, PAUSED, EXPIRED)
//   - MAX_TENS    : largest legal tens digit (5)
//   - MAX_ONES    : largest legal ones digit (9)
//   - clamp_tens / clamp_ones : saturate an out-of-range BCD load digit
// -----------------------------------------------------------------------------
package countdown_timer_60_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [2:0] MAX_TENS = 3'd5;
  localparam logic [3:0] MAX_ONES = 4'd9;

  // Any tens value above 5 would describe 60+ seconds; saturate to 5.
  function automatic logic [2:0] clamp_tens(input logic [2:0] value);
    return (value > MAX_TENS) ? MAX_TENS : value;
  endfunction

  // Codes 10..15 are not BCD; saturate to 9.
  function automatic logic [3:0] clamp_ones(input logic [3:0] value);
    return (value > MAX_ONES) ? MAX_ONES : value;
  endfunction

endpackage

// File: rtl/countdown_timer_60_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// One-second prescaler. Counts 0..DIVIDE-1 while Enable is high and raises
// Tick during the cycle in which the count sits at DIVIDE-1, so the owner
// sees the tick on the same edge the counter wraps back to 0.
//
// Ports
//   Clockin : clock, rising edge
//   Reset   : asynchronous active-high reset, count -> 0
//   Enable  : count advances only while high; low holds the current value
//   Zero    : synchronous clear of the count, overrides Enable
//   Tick    : terminal-count indication (combinational from the count)
// -----------------------------------------------------------------------------
module tick_gen #(
  parameter int unsigned DIVIDE = 50000000
) (
  input  logic Clockin,
  input  logic Reset,
  input  logic Enable,
  input  logic Zero,
  output logic Tick
);

  // DIVIDE is at least 2, so $clog2 is at least 1.
  localparam int unsigned CNT_W = $clog2(DIVIDE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last = (count == LAST);

  // A pending Zero means the owner is restarting the interval, so a tick in
  // that same cycle is meaningless and is suppressed.
  assign Tick = Enable & ~Zero & at_last;

  always_ff @(posedge Clockin or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (Zero) begin
      count <= '0;
    end else if (Enable) begin
      count <= at_last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_60.sv
// -----------------------------------------------------------------------------
// countdown_timer_60
// BCD countdown timer, 00..59 seconds, one decrement per DIVIDE clocks.
//
// Ports
//   Clockin  : clock, rising edge
//   Reset    : asynchronous active-high reset to IDLE / 00
//   Start    : load-and-run from IDLE/EXPIRED, resume from PAUSED
//   Pause    : halt counting from RUN (digits and prescaler frozen)
//   Clear    : abort to IDLE / 00 from any state (highest priority)
//   LoadTens : BCD tens of start value (values above 5 saturate to 5)
//   LoadOnes : BCD ones of start value (values above 9 saturate to 9)
//   Tens     : remaining seconds, tens digit
//   Ones     : remaining seconds, ones digit
//   Running  : high while in RUN
//   Done     : one-cycle pulse on the edge the count reaches 00
//   Expired  : high while in EXPIRED
//
// All outputs come straight from flops. Running/Expired are registered
// decodes of the next state so they line up with the state register.
// -----------------------------------------------------------------------------
module countdown_timer_60
  import countdown_timer_60_pkg::*;
#(
  parameter int unsigned DIVIDE = 50000000
) (
  input  logic       Clockin,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Clear,
  input  logic [2:0] LoadTens,
  input  logic [3:0] LoadOnes,
  output logic [2:0] Tens,
  output logic [3:0] Ones,
  output logic       Running,
  output logic       Done,
  output logic       Expired
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] tens_nxt;
  logic [3:0] ones_nxt;
  logic       done_nxt;

  logic       tick;
  logic       presc_en;
  logic       presc_zero;
  logic       idle_like;

  logic [2:0] ld_tens;
  logic [3:0] ld_ones;
  logic       ld_zero;
  logic       at_one;

  assign ld_tens   = clamp_tens(LoadTens);
  assign ld_ones   = clamp_ones(LoadOnes);
  assign ld_zero   = (ld_tens == 3'd0) && (ld_ones == 4'd0);

  // The tick that is about to be consumed takes the count from 01 to 00.
  assign at_one    = (Tens == 3'd0) && (Ones == 4'd1);

  assign idle_like = (state == IDLE) || (state == EXPIRED);

  // The prescaler only runs in RUN, so in PAUSED it keeps its partial
  // interval and a resume finishes that interval rather than restarting it.
  assign presc_en   = (state == RUN);
  assign presc_zero = Clear | (Start & idle_like);

  tick_gen #(
    .DIVIDE(DIVIDE)
  ) u_tick_gen (
    .Clockin(Clockin),
    .Reset  (Reset),
    .Enable (presc_en),
    .Zero   (presc_zero),
    .Tick   (tick)
  );

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clockin or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      Tens    <= 3'd0;
      Ones    <= 4'd0;
      Running <= 1'b0;
      Done    <= 1'b0;
      Expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      Tens    <= tens_nxt;
      Ones    <= ones_nxt;
      Running <= (state_nxt == RUN);
      Done    <= done_nxt;
      Expired <= (state_nxt == EXPIRED);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Clear beats Start beats Pause everywhere.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (Clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, EXPIRED: begin
          if (Start) begin
            state_nxt = ld_zero ? EXPIRED : RUN;
          end
        end
        RUN: begin
          // Reaching 00 wins over a simultaneous Pause. A Start in RUN is
          // ignored but, being higher priority, also masks a Pause.
          if (tick && at_one) begin
            state_nxt = EXPIRED;
          end else if (!Start && Pause) begin
            state_nxt = PAUSED;
          end
        end
        PAUSED: begin
          if (Start) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-output logic: digit load / decrement and the Done pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    tens_nxt = Tens;
    ones_nxt = Ones;
    done_nxt = 1'b0;
    if (Clear) begin
      tens_nxt = 3'd0;
      ones_nxt = 4'd0;
    end else begin
      case (state)
        IDLE, EXPIRED: begin
          if (Start) begin
            tens_nxt = ld_tens;
            ones_nxt = ld_ones;
            // A 00 load expires immediately and still reports completion.
            done_nxt = ld_zero;
          end
        end
        RUN: begin
          // A tick always applies in RUN, including alongside a Pause.
          if (tick) begin
            if (Ones != 4'd0) begin
              ones_nxt = Ones - 4'd1;
            end else begin
              ones_nxt = MAX_ONES;
              tens_nxt = Tens - 3'd1;
            end
            done_nxt = at_one;
          end
        end
        default: begin
          tens_nxt = Tens;
          ones_nxt = Ones;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_60.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer_60
// Directed bench for countdown_timer_60 with DIVIDE=4. Inputs change and
// outputs are sampled on the falling edge; expected values are hand-derived.
// Digits are compared as {1'b0,Tens,Ones}, which reads as BCD in hex
// (e.g. 8'h59 means 5/9). Flags are compared as {Running,Done,Expired}.
// -----------------------------------------------------------------------------
module tb_countdown_timer_60;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       clear;
  logic [2:0] load_tens;
  logic [3:0] load_ones;
  logic [2:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       expired;

  int checks = 0;
  int errors = 0;

  countdown_timer_60 #(
    .DIVIDE(4)
  ) dut (
    .Clockin (clk),
    .Reset   (rst),
    .Start   (start),
    .Pause   (pause),
    .Clear   (clear),
    .LoadTens(load_tens),
    .LoadOnes(load_ones),
    .Tens    (tens),
    .Ones    (ones),
    .Running (running),
    .Done    (done),
    .Expired (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] dig();
    return {1'b0, tens, ones};
  endfunction

  function automatic logic [7:0] flg();
    return {5'd0, running, done, expired};
  endfunction

  // One-cycle Start pulse; returns on the falling edge just after the
  // capturing rising edge (call that edge S).
  task automatic pulse_start(input logic [2:0] t, input logic [3:0] o);
    load_tens = t;
    load_ones = o;
    start     = 1'b1;
    cyc(1);
    start     = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    pause     = 1'b0;
    clear     = 1'b0;
    load_tens = 3'd0;
    load_ones = 4'd0;
    cyc(2);
    chk("reset_digits", dig(), 8'h00);
    chk("reset_flags",  flg(), 8'h00);
    rst = 1'b0;
    cyc(2);
    chk("idle_after_reset", flg(), 8'h00);

    // 0/5: first decrement 4 cycles after Start, expiry 20 cycles after.
    pulse_start(3'd0, 4'd5);
    chk("load05_digits", dig(), 8'h05);
    chk("load05_flags",  flg(), 8'h04);
    cyc(3);
    chk("s3_no_tick", dig(), 8'h05);
    cyc(1);
    chk("s4_first_tick", dig(), 8'h04);
    cyc(15);
    chk("s19_digits", dig(), 8'h01);
    chk("s19_flags",  flg(), 8'h04);
    cyc(1);
    chk("s20_digits", dig(), 8'h00);
    chk("s20_done",   flg(), 8'h03);
    cyc(1);
    chk("s21_expired_hold", flg(), 8'h01);
    cyc(3);
    chk("expired_digits_hold", dig(), 8'h00);
    chk("expired_flags_hold",  flg(), 8'h01);

    // 1/0 from EXPIRED: BCD borrow on first tick.
    pulse_start(3'd1, 4'd0);
    chk("load10_digits", dig(), 8'h10);
    cyc(4);
    chk("borrow_09", dig(), 8'h09);

    // Clear then clamped load 7/12 -> 5/9.
    pulse_clear();
    chk("clear_digits", dig(), 8'h00);
    chk("clear_flags",  flg(), 8'h00);
    pulse_start(3'd7, 4'd12);
    chk("clamp_digits",  dig(), 8'h59);
    chk("clamp_running", flg(), 8'h04);

    // Run 2 cycles, Pause held 10 cycles, then resume.
    cyc(1);
    pause = 1'b1;
    cyc(10);
    chk("paused_flags",  flg(), 8'h00);
    chk("paused_digits", dig(), 8'h59);
    pause = 1'b0;
    pulse_start(3'd0, 4'd3);
    chk("resume_running", flg(), 8'h04);
    chk("resume_no_reload", dig(), 8'h59);
    cyc(1);
    chk("resume_r1", dig(), 8'h59);
    cyc(1);
    chk("resume_r2_tick", dig(), 8'h58);

    // Start in RUN is ignored; next tick 4 later, coinciding with Pause.
    pulse_start(3'd2, 4'd2);
    chk("start_in_run_ignored", dig(), 8'h58);
    cyc(2);
    pause = 1'b1;
    cyc(1);
    pause = 1'b0;
    chk("tick_and_pause_digits", dig(), 8'h57);
    chk("tick_and_pause_flags",  flg(), 8'h00);

    // Start with 00 -> EXPIRED and Done on the same edge.
    pulse_clear();
    pulse_start(3'd0, 4'd0);
    chk("load00_flags",  flg(), 8'h03);
    chk("load00_digits", dig(), 8'h00);
    cyc(1);
    chk("load00_done_once", flg(), 8'h01);

    // Clear and Start together: Clear wins.
    load_tens = 3'd3;
    load_ones = 4'd3;
    clear     = 1'b1;
    start     = 1'b1;
    cyc(1);
    clear     = 1'b0;
    start     = 1'b0;
    chk("clear_beats_start_digits", dig(), 8'h00);
    chk("clear_beats_start_flags",  flg(), 8'h00);

    // Asynchronous reset mid-count at 0/3.
    pulse_start(3'd0, 4'd4);
    cyc(4);
    chk("pre_reset_03", dig(), 8'h03);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_digits", dig(), 8'h00);
    chk("async_reset_flags",  flg(), 8'h00);
    cyc(2);
    chk("in_reset_no_done", flg(), 8'h00);
    rst = 1'b0;
    cyc(8);
    chk("post_reset_idle_digits", dig(), 8'h00);
    chk("post_reset_idle_flags",  flg(), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/countdown_timer_60.md
COUNTDOWN_TIMER_60 -- requirements
Module: countdown_timer_60

Interface
REQ-001 Parameter DIVIDE, default 50000000, Clockin cycles per one-second tick; legal range 2..2^26.
REQ-002 Clockin  input  1  sole clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  synchronous one-cycle request to load and run, or to resume.
REQ-005 Pause  input  1  synchronous request to halt counting.
REQ-006 Clear  input  1  synchronous abort to IDLE with count 00.
REQ-007 LoadTens  input  3  BCD tens digit of start value.
REQ-008 LoadOnes  input  4  BCD ones digit of start value.
REQ-009 Tens  output  3  current remaining seconds, tens digit, 0..5.
REQ-010 Ones  output  4  current remaining seconds, ones digit, 0..9.
REQ-011 Running  output  1  high while state is RUN.
REQ-012 Done  output  1  one-cycle pulse on reaching 00.
REQ-013 Expired  output  1  high while state is EXPIRED.

Function
REQ-014 FSM states SHALL be IDLE, RUN, PAUSED, EXPIRED; all outputs SHALL be registered.
REQ-015 Input priority SHALL be Clear > Start > Pause in every state.
REQ-016 Clear SHALL, from any state, go to IDLE, set Tens=0, Ones=0, zero the prescaler.
REQ-017 Start in IDLE or EXPIRED SHALL load LoadTens/LoadOnes, zero the prescaler, enter RUN.
REQ-018 Load clamping: LoadTens>5 SHALL load 5; LoadOnes>9 SHALL load 9.
REQ-019 Start with (clamped) load value 00 SHALL enter EXPIRED directly and pulse Done on the same edge.
REQ-020 Prescaler SHALL count 0..DIVIDE-1 only in RUN; terminal count produces an internal tick and wraps to 0.
REQ-021 First decrement SHALL occur exactly DIVIDE cycles after the Start edge; subsequent ones every DIVIDE cycles.
REQ-022 Tick decrement: Ones>0 -> Ones-1; Ones==0 -> Ones=9, Tens-1 (BCD borrow).
REQ-023 Tick taking count to 00 SHALL, on that same edge, enter EXPIRED and assert Done for exactly one cycle.
REQ-024 Pause in RUN SHALL enter PAUSED and freeze both digits and the prescaler value.
REQ-025 Tick and Pause in the same cycle: decrement SHALL apply, then PAUSED is entered.
REQ-026 Start in PAUSED SHALL resume RUN from the frozen prescaler value, no reload.
REQ-027 Start or Pause in RUN other than per REQ-024 SHALL be ignored; Pause in IDLE/EXPIRED ignored.
REQ-028 EXPIRED SHALL hold Tens=0, Ones=0, Expired=1 until Clear or Start.
REQ-029 Prescaler width SHALL be ceil(log2(DIVIDE)) bits; no overflow beyond DIVIDE-1.

Reset
REQ-030 Reset high SHALL immediately force IDLE, Tens=0, Ones=0, prescaler=0, Running=0, Done=0, Expired=0.
REQ-031 Reset asserted mid-count SHALL abort without a Done pulse; after release, block waits in IDLE for Start.

Structure
REQ-032 Shared package SHALL hold the state enumeration, MAX_TENS=5, MAX_ONES=9 constants.
REQ-033 Prescaler SHALL be one sub-module, tick_gen (parameter DIVIDE; ports Clockin, Reset, Enable, Zero, Tick).
REQ-034 tick_gen Zero SHALL clear its count synchronously; Enable low SHALL hold it.

Verification (DIVIDE=4)
REQ-035 Reset, Start with 0/5 -> first decrement 4 cycles later to 0/4; Done pulse and EXPIRED 20 cycles after Start.
REQ-036 Start with 1/0 -> one tick later Tens=0, Ones=9 (borrow).
REQ-037 Start with 7/12 -> loads 5/9; Running=1.
REQ-038 Run 2 cycles, Pause 10 cycles, Start -> next decrement exactly 2 cycles after resume.
REQ-039 Start with 0/0 -> EXPIRED and single Done pulse same edge; Clear and Start same cycle -> IDLE, 00.
REQ-040 Reset pulse asynchronously mid-count at 0/3 -> all outputs zero before next edge, no Done.
